// File: rtl/riscv_pkg.sv
// Core-wide architectural widths used by the trace path.
// Sv39 virtual addresses on a 64-bit hart.
package riscv;
  localparam int unsigned XLEN = 64;
  localparam int unsigned VLEN = 39;
endpackage

// File: rtl/rvfi_pkg.sv
// RVFI commit-port record as produced by each hart commit slot.
// Only the fields consumed by trace capture are carried here.
package rvfi_pkg;
  typedef struct packed {
    logic                     valid;
    logic [31:0]              insn;
    logic                     trap;
    logic [1:0]               mode;
    logic [4:0]               rd_addr;
    logic [riscv::XLEN-1:0]   rd_wdata;
    logic [riscv::VLEN-1:0]   pc_rdata;
  } rvfi_instr_t;
endpackage

// File: rtl/rvfi_trace_pkg.sv
// Shared types and constants for the RVFI trace buffer: record layout,
// FP destination decode, end-of-test instruction and FSM encoding.
package rvfi_trace_pkg;
  localparam logic [6:0] OPC_FMADD   = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB   = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB  = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD  = 7'b1001111;
  localparam logic [6:0] OPC_LOAD_FP = 7'b0000111;
  localparam logic [6:0] OPC_OP_FP   = 7'b1010011;

  // OP-FP groups whose destination is an integer register
  localparam logic [5:0] F6_FMV_X_CLASS = 6'b111000;
  localparam logic [5:0] F6_FCMP        = 6'b101000;
  localparam logic [5:0] F6_FCVT_TO_INT = 6'b110000;

  localparam logic [31:0] ECALL = 32'h00000073;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic        trap;
    logic [1:0]  mode;
    logic [4:0]  rd_addr;
    logic        fp_rd;
    logic [63:0] pc;
    logic [31:0] insn;
    logic [63:0] rd_wdata;
  } trace_rec_t;

  function automatic logic is_fp_rd(input logic [31:0] insn);
    logic [6:0] opc;
    logic [5:0] f6;
    opc = insn[6:0];
    f6  = insn[31:26];
    if (opc inside {OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD, OPC_LOAD_FP}) begin
      return 1'b1;
    end
    if (opc == OPC_OP_FP) begin
      return !(f6 inside {F6_FMV_X_CLASS, F6_FCMP, F6_FCVT_TO_INT});
    end
    return 1'b0;
  endfunction
endpackage

// File: rtl/rvfi_trace_mpfifo.sv
// Circular buffer accepting 0..NR_PUSH writes per cycle and one read per cycle,
// with first-word-fall-through head and extra-bit pointers for full/empty.
module rvfi_trace_mpfifo #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned NR_PUSH = 2,
  parameter type         T       = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear,
  input  logic [$clog2(DEPTH):0]     push_cnt,
  input  T                           push_data [NR_PUSH],
  input  logic                       pop,
  output logic                       head_valid,
  output T                           head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW-1:0] wr_idx [NR_PUSH];

  assign count      = wr_ptr - rd_ptr;
  assign head_valid = (count != '0);
  assign head       = head_valid ? mem[rd_ptr[AW-1:0]] : '0;

  for (genvar j = 0; j < NR_PUSH; j++) begin : g_idx
    assign wr_idx[j] = wr_ptr[AW-1:0] + AW'(j);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + push_cnt;
      if (pop && head_valid) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Storage is not reset; the pointers alone define what is live
  always_ff @(posedge clk_i) begin
    for (int j = 0; j < NR_PUSH; j++) begin
      if (!clear && ((AW+1)'(j) < push_cnt)) begin
        mem[wr_idx[j]] <= push_data[j];
      end
    end
  end
endmodule

// File: rtl/rvfi_trace_buffer.sv
// Packs RVFI commits into trace records, buffers them for a ready/valid sink,
// and detects end of test (ecall or watchdog) while keeping run statistics.
module rvfi_trace_buffer
  import rvfi_trace_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 16,
  parameter logic        TRACE_TRAPS     = 1'b1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        clear_i,
  input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
  input  logic [CNT_W-1:0]                            timeout_i,
  output logic                                        rec_valid_o,
  input  logic                                        rec_ready_i,
  output trace_rec_t                                  rec_o,
  output logic [CNT_W-1:0]                            cycles_o,
  output logic [CNT_W-1:0]                            retired_o,
  output logic [CNT_W-1:0]                            dropped_o,
  output logic                                        done_o,
  output logic                                        timeout_o
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e        state, state_n;
  logic          capture;
  logic          counting;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic [CW-1:0] push_cnt;
  logic [CW-1:0] ret_cnt;
  logic [CW-1:0] drop_cnt;
  logic          ecall_hit;
  logic          watchdog_hit;
  trace_rec_t    cand_rec  [NR_COMMIT_PORTS];
  trace_rec_t    push_data [NR_COMMIT_PORTS];

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CW-1:0]    b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      cand_rec[i]          = '0;
      cand_rec[i].trap     = !rvfi_i[i].valid;
      cand_rec[i].mode     = rvfi_i[i].mode;
      cand_rec[i].rd_addr  = rvfi_i[i].rd_addr;
      cand_rec[i].fp_rd    = is_fp_rd(rvfi_i[i].insn);
      cand_rec[i].pc       = 64'($signed(rvfi_i[i].pc_rdata));
      cand_rec[i].insn     = rvfi_i[i].insn;
      cand_rec[i].rd_wdata = 64'(rvfi_i[i].rd_wdata);
    end
  end

  // Free space is taken from the start of the cycle; a same-cycle pop does not count
  assign free = CW'(DEPTH) - count;

  always_comb begin
    push_cnt  = '0;
    ret_cnt   = '0;
    drop_cnt  = '0;
    ecall_hit = 1'b0;
    for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
      push_data[j] = '0;
    end
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      if (capture && !ecall_hit &&
          (rvfi_i[i].valid || (TRACE_TRAPS && rvfi_i[i].trap))) begin
        if (push_cnt < free) begin
          for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
            if (push_cnt == CW'(j)) begin
              push_data[j] = cand_rec[i];
            end
          end
          push_cnt = push_cnt + CW'(1);
          if (rvfi_i[i].valid) begin
            ret_cnt = ret_cnt + CW'(1);
          end
          if (rvfi_i[i].insn == ECALL) begin
            ecall_hit = 1'b1;
          end
        end else begin
          drop_cnt = drop_cnt + CW'(1);
        end
      end
    end
  end

  assign watchdog_hit = capture && (timeout_i != '0) && (cycles_o >= timeout_i) && !ecall_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_RUN;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (clear_i) begin
      state_n = ST_RUN;
    end else begin
      unique case (state)
        ST_RUN:   if (ecall_hit || watchdog_hit) state_n = ST_DRAIN;
        ST_DRAIN: if (count == '0) state_n = ST_DONE;
        ST_DONE:  state_n = ST_DONE;
        default:  state_n = ST_RUN;
      endcase
    end
  end

  always_comb begin
    capture  = (state == ST_RUN);
    counting = (state != ST_DONE);
    done_o   = (state == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycles_o  <= '0;
      retired_o <= '0;
      dropped_o <= '0;
      timeout_o <= 1'b0;
    end else if (clear_i) begin
      cycles_o  <= '0;
      retired_o <= '0;
      dropped_o <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (counting) begin
        cycles_o <= sat_add(cycles_o, CW'(1));
      end
      retired_o <= sat_add(retired_o, ret_cnt);
      dropped_o <= sat_add(dropped_o, drop_cnt);
      timeout_o <= timeout_o | watchdog_hit;
    end
  end

  rvfi_trace_mpfifo #(
    .DEPTH   (DEPTH),
    .NR_PUSH (NR_COMMIT_PORTS),
    .T       (trace_rec_t)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear      (clear_i),
    .push_cnt   (push_cnt),
    .push_data  (push_data),
    .pop        (rec_ready_i),
    .head_valid (rec_valid_o),
    .head       (rec_o),
    .count      (count)
  );
endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Scoreboard bench for rvfi_trace_buffer: expected records are queued as
// commits are driven and compared as the sink drains them.
module tb_rvfi_trace_buffer;
  import rvfi_trace_pkg::*;

  localparam int NP    = 2;
  localparam int DEPTH = 4;
  localparam logic [31:0] ECALL_INSN = 32'h00000073;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  rvfi_pkg::rvfi_instr_t [NP-1:0] rvfi;
  logic [31:0] timeout;
  logic        ready;

  logic        rec_valid;
  trace_rec_t  rec;
  logic [31:0] cycles, retired, dropped;
  logic        done, tmo;

  logic        n_valid;
  trace_rec_t  n_rec;
  logic [31:0] n_cycles, n_retired, n_dropped;
  logic        n_done, n_tmo;

  always #5 clk = ~clk;

  rvfi_trace_buffer #(.NR_COMMIT_PORTS(NP), .DEPTH(DEPTH), .TRACE_TRAPS(1'b1), .CNT_W(32)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .rvfi_i(rvfi), .timeout_i(timeout),
    .rec_valid_o(rec_valid), .rec_ready_i(ready), .rec_o(rec),
    .cycles_o(cycles), .retired_o(retired), .dropped_o(dropped),
    .done_o(done), .timeout_o(tmo));

  rvfi_trace_buffer #(.NR_COMMIT_PORTS(NP), .DEPTH(DEPTH), .TRACE_TRAPS(1'b0), .CNT_W(32)) u_notrap (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .rvfi_i(rvfi), .timeout_i(timeout),
    .rec_valid_o(n_valid), .rec_ready_i(1'b1), .rec_o(n_rec),
    .cycles_o(n_cycles), .retired_o(n_retired), .dropped_o(n_dropped),
    .done_o(n_done), .timeout_o(n_tmo));

  int errors = 0;
  int checks = 0;

  trace_rec_t  q[$];
  logic [31:0] m_cyc, m_ret, m_drop;
  int          m_st;   // 0 run, 1 drain, 2 done
  logic        m_tmo;

  task automatic check_val(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_fp(input logic [31:0] insn);
    case (insn[6:0])
      7'h43, 7'h47, 7'h4b, 7'h4f, 7'h07: return 1'b1;
      7'h53: return !(insn[31:26] == 6'h38 || insn[31:26] == 6'h28 || insn[31:26] == 6'h30);
      default: return 1'b0;
    endcase
  endfunction

  function automatic trace_rec_t mk_rec(input rvfi_pkg::rvfi_instr_t p);
    trace_rec_t r;
    r.trap     = !p.valid;
    r.mode     = p.mode;
    r.rd_addr  = p.rd_addr;
    r.fp_rd    = exp_fp(p.insn);
    r.pc       = {{(64-riscv::VLEN){p.pc_rdata[riscv::VLEN-1]}}, p.pc_rdata};
    r.insn     = p.insn;
    r.rd_wdata = p.rd_wdata;
    return r;
  endfunction

  task automatic set_port(input int i, input logic v, input logic t, input logic [63:0] pc,
                          input logic [31:0] insn, input logic [4:0] rd, input logic [63:0] wd);
    rvfi[i].valid    = v;
    rvfi[i].trap     = t;
    rvfi[i].pc_rdata = pc[riscv::VLEN-1:0];
    rvfi[i].insn     = insn;
    rvfi[i].rd_addr  = rd;
    rvfi[i].rd_wdata = wd;
    rvfi[i].mode     = 2'b11;
  endtask

  task automatic idle();
    rvfi = '0;
  endtask

  task automatic model_reset();
    q.delete();
    m_cyc = 0; m_ret = 0; m_drop = 0; m_st = 0; m_tmo = 1'b0;
  endtask

  // Called just after a falling edge with inputs settled; advances one clock.
  task automatic tick();
    int free, n, nst;
    bit stop;
    logic [31:0] rt, dr;
    trace_rec_t newq[$];
    check_val("rec_valid", rec_valid, q.size() != 0);
    if (q.size() != 0) check_val("rec", rec, q[0]);
    else               check_val("rec_idle", rec, '0);
    check_val("retired", retired, m_ret);
    check_val("dropped", dropped, m_drop);
    check_val("cycles", cycles, m_cyc);
    check_val("done", done, m_st == 2);
    check_val("timeout", tmo, m_tmo);
    if (clear) begin
      model_reset();
    end else begin
      free = DEPTH - q.size(); n = 0; stop = 0; nst = m_st; rt = 0; dr = 0;
      if (m_st == 0) begin
        for (int i = 0; i < NP; i++) begin
          if (!stop && (rvfi[i].valid || rvfi[i].trap)) begin
            if (n < free) begin
              newq.push_back(mk_rec(rvfi[i]));
              n++;
              if (rvfi[i].valid) rt++;
              if (rvfi[i].insn == ECALL_INSN) stop = 1;
            end else begin
              dr++;
            end
          end
        end
        if (stop) nst = 1;
        else if (timeout != 0 && m_cyc >= timeout) begin
          nst = 1;
          m_tmo = 1'b1;
        end
      end else if (m_st == 1 && q.size() == 0) begin
        nst = 2;
      end
      if (m_st != 2) m_cyc = m_cyc + 1;
      m_ret  = m_ret + rt;
      m_drop = m_drop + dr;
      if (q.size() != 0 && ready) void'(q.pop_front());
      foreach (newq[k]) q.push_back(newq[k]);
      m_st = nst;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    idle();
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; ready = 1'b1; timeout = '0; rvfi = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_valid", rec_valid, 1'b0);
    check_val("rst_rec", rec, '0);
    check_val("rst_cycles", cycles, 0);
    check_val("rst_retired", retired, 0);
    check_val("rst_dropped", dropped, 0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_timeout", tmo, 1'b0);
    rst_n = 1'b1;

    // Two in-order commits, sink always ready
    set_port(0, 1, 0, 64'h80000000, 32'h00100093, 5'd1, 64'h1);
    set_port(1, 1, 0, 64'h80000004, 32'h00200113, 5'd2, 64'h2);
    tick();
    idle();
    check_val("t1_first_pc", rec.pc, 64'h80000000);
    tick();
    check_val("t1_second_pc", rec.pc, 64'h80000004);
    repeat (2) tick();
    check_val("t1_retired", retired, 2);

    // FP destination decode
    set_port(0, 1, 0, 64'h80000008, 32'hE2000553, 5'd10, 64'h55);
    set_port(1, 1, 0, 64'h8000000C, 32'h00003187, 5'd3, 64'h66);
    tick();
    idle();
    check_val("fmv_fp_rd", rec.fp_rd, 1'b0);
    tick();
    check_val("fld_fp_rd", rec.fp_rd, 1'b1);
    check_val("fld_rd", rec.rd_addr, 5'd3);
    repeat (2) tick();

    // Overflow with a stalled sink
    ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_port(0, 1, 0, 64'h80001000 + 64'(16*c), 32'h00000013, 5'd4, 64'(c));
      set_port(1, 1, 0, 64'h80001004 + 64'(16*c), 32'h00000013, 5'd5, 64'(c+8));
      tick();
    end
    idle();
    tick();
    check_val("ovf_dropped", dropped, 2);
    check_val("ovf_head_pc", rec.pc, 64'h80001000);
    ready = 1'b1;
    repeat (6) tick();

    // Ecall with a full-but-one buffer: port 1 ignored, not dropped
    ready = 1'b0;
    set_port(0, 1, 0, 64'h80002000, 32'h00000013, 5'd6, 64'h0);
    set_port(1, 1, 0, 64'h80002004, 32'h00000013, 5'd7, 64'h0);
    tick();
    idle();
    set_port(0, 1, 0, 64'h80002008, 32'h00000013, 5'd8, 64'h0);
    tick();
    set_port(0, 1, 0, 64'h8000200C, ECALL_INSN, 5'd0, 64'h0);
    set_port(1, 1, 0, 64'h80002010, 32'h00000013, 5'd9, 64'h0);
    tick();
    idle();
    check_val("ecall_dropped", dropped, 2);
    ready = 1'b1;
    repeat (6) tick();
    check_val("ecall_done", done, 1'b1);
    check_val("ecall_timeout", tmo, 1'b0);
    do_clear();

    // Watchdog termination
    timeout = 32'd10;
    repeat (16) tick();
    check_val("wd_timeout", tmo, 1'b1);
    check_val("wd_done", done, 1'b1);
    check_val("wd_cycles", cycles, 12);
    timeout = '0;
    do_clear();

    // Trapping port with valid low
    set_port(0, 0, 1, 64'h80003000, 32'h00000000, 5'd0, 64'h0);
    tick();
    idle();
    check_val("trap_bit", rec.trap, 1'b1);
    check_val("trap_retired", retired, 0);
    check_val("notrap_valid", n_valid, 1'b0);
    check_val("notrap_retired", n_retired, 0);
    check_val("notrap_dropped", n_dropped, 0);
    repeat (2) tick();

    // Clear while draining a non-empty buffer
    ready = 1'b0;
    set_port(0, 1, 0, 64'h80004000, 32'h00000013, 5'd1, 64'h0);
    set_port(1, 1, 0, 64'h80004004, 32'h00000013, 5'd2, 64'h0);
    tick();
    idle();
    set_port(0, 1, 0, 64'h80004008, ECALL_INSN, 5'd0, 64'h0);
    tick();
    idle();
    repeat (2) tick();
    do_clear();
    check_val("clr_valid", rec_valid, 1'b0);
    check_val("clr_retired", retired, 0);
    check_val("clr_done", done, 1'b0);
    set_port(0, 1, 0, 64'h80005000, 32'h00000013, 5'd3, 64'h7);
    tick();
    idle();
    ready = 1'b1;
    repeat (3) tick();

    // Random traffic, no end-of-test events
    do_clear();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NP; i++) begin
        logic [63:0] pc;
        logic [31:0] insn;
        pc   = {$urandom, $urandom};
        insn = $urandom;
        if (insn == ECALL_INSN) insn = insn ^ 32'h1;
        set_port(i, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, pc, insn,
                 5'($urandom), {$urandom, $urandom});
        rvfi[i].mode = 2'($urandom);
      end
      ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    idle();
    ready = 1'b1;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rvfi_trace_buffer.md
# rvfi_trace_buffer

Synthesizable, parametrised trace capture stage fed by the per-hart RVFI commit ports. Each cycle it packs up to NR_COMMIT_PORTS retired or trapping instructions into fixed-format trace records and stores them in a circular buffer. It drains the records one per cycle on a ready/valid stream toward a trace sink (UART/DMA/testbench writer). It also owns end-of-test detection (ecall commit, cycle-limit watchdog) and retire/drop/cycle statistics.

## Interface
- NR_COMMIT_PORTS, 2, number of RVFI commit ports sampled per cycle (1..4)
- DEPTH, 16, record buffer entries; power of two, >= NR_COMMIT_PORTS
- TRACE_TRAPS, 1'b1, when 1 trapping non-valid ports also produce records
- CNT_W, 32, width of cycles/retired/dropped counters
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous clear: flush buffer, zero counters, FSM to RUN
- rvfi_i  in  NR_COMMIT_PORTS x rvfi_pkg::rvfi_instr_t  commit ports
- timeout_i  in  CNT_W  cycle limit; 0 disables watchdog
- rec_valid_o  out  1  head record available
- rec_ready_i  in  1  sink accepts head record
- rec_o  out  rvfi_trace_pkg::trace_rec_t  head record
- cycles_o  out  CNT_W  cycles since reset/clear, saturating
- retired_o  out  CNT_W  valid commits captured, saturating
- dropped_o  out  CNT_W  records lost to full buffer, saturating
- done_o  out  1  FSM in DONE
- timeout_o  out  1  sticky: termination caused by watchdog

## Operation
- Record fields: trap (1), mode (2), rd_addr (5), fp_rd (1), pc (64, pc_rdata sign-extended from riscv::VLEN), insn (32), rd_wdata (64, zero-extended from riscv::XLEN).
- Record source: port i is a candidate if valid, or if trap with TRACE_TRAPS=1. trap field = !valid.
- fp_rd=1 if insn[6:0] is in {1001111, 1001011, 1000111, 1000011, 0000111}. It is also 1 if insn[6:0]=1010011 and insn[31:26] is not in {111000, 101000, 110000}. Otherwise 0.
- Candidates are pushed in ascending port order.
- free = DEPTH minus occupancy at the start of the cycle. A same-cycle pop does not add space.
- If there are more candidates than free, the first `free` candidates are pushed. The rest are dropped and dropped_o increments by the drop count.
- retired_o increments by the number of pushed records with trap=0.
- Pop: head leaves when rec_valid_o && rec_ready_i. rec_o holds stable while rec_valid_o && !rec_ready_i.
- FSM states: RUN, DRAIN, DONE.
  - RUN: captures records.
  - RUN->DRAIN when a pushed record has insn==32'h00000073. That record is stored. Higher-index ports in the same cycle and all later cycles are ignored (not counted as dropped).
  - RUN->DRAIN when timeout_i!=0 and cycles_o>=timeout_i; timeout_o is set. If both events occur in the same cycle, the ecall wins and timeout_o stays 0.
  - DRAIN: no capture; DRAIN->DONE when the buffer is empty.
  - DONE: terminal until clear_i or reset.
- cycles_o increments every cycle in RUN and DRAIN. It freezes in DONE.
- All counters saturate at all-ones.
- clear_i has priority over every event in its cycle.

## Timing
- Reset/clear values: rec_valid_o=0, rec_o=0, all counters 0, done_o=0, timeout_o=0, FSM=RUN, buffer empty.
- Capture-to-output latency is 1 cycle: a record pushed at edge k is on rec_o after edge k if the buffer was empty.
- Output is first-word-fall-through from a registered buffer. There is no combinational path from rvfi_i to rec_o or rec_valid_o.
- Full sustained throughput is 1 record/cycle out, up to NR_COMMIT_PORTS records/cycle in.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.
- done_o rises on the edge after the pop that empties the buffer in DRAIN. If the buffer is already empty on entering DRAIN, done_o rises one cycle after entry.
- Asynchronous reset mid-drain discards all buffered records.

## Structure
- Package rvfi_trace_pkg holds:
  - trace_rec_t
  - FP opcode constants
  - ECALL constant 32'h00000073
  - state enum
- Sub-module rvfi_trace_mpfifo: multi-push (0..NR_COMMIT_PORTS per cycle), single-pop circular buffer. It reports occupancy and is parametrised by DEPTH, NR_PUSH and the element type.
- Top level holds port packing, fp decode, FSM and counters.

## Test plan
- 2 ports, both valid, pc 0x80000000/0x80000004, sink always ready -> two records out on consecutive cycles in port order; retired_o=2.
- Port 1 valid with an FLD opcode (0000111), rd_addr=3 -> fp_rd=1. Port 0 FMV.X.D (1010011, funct6 111000) -> fp_rd=0.
- DEPTH=4, sink stalled, 3 cycles of 2 valid commits -> 4 stored, dropped_o=2, rec_o holds the first record stable.
- Port 0 commits 0x00000073, port 1 valid in the same cycle, 3 records buffered -> port 1 ignored, dropped_o unchanged, done_o rises after the 4th pop.
- timeout_i=10, no ecall -> DRAIN entered when cycles_o=10, timeout_o=1, cycles_o stops at DONE.
- Trap on port 0 with valid=0, TRACE_TRAPS=1 -> record with trap=1 and retired_o unchanged. With TRACE_TRAPS=0 -> no record.
- clear_i while in DRAIN with the buffer non-empty -> next cycle rec_valid_o=0, counters 0, capture resumes.
